// File: rtl/mips_regfile_port_sched_if.sv
// Request, read-grant, reservation and register-file write signals
// shared between the port scheduler and its clients.
interface mips_regfile_port_sched_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int NREG = 1 << ADDR_W;

    logic              ReqValid0;
    logic [ADDR_W-1:0] ReqAddr0;
    logic [DATA_W-1:0] ReqData0;
    logic              ReqReady0;
    logic              ReqValid1;
    logic [ADDR_W-1:0] ReqAddr1;
    logic [DATA_W-1:0] ReqData1;
    logic              ReqReady1;
    logic              ReadReq;
    logic              ReadGnt;
    logic              Reserve;
    logic [ADDR_W-1:0] ReserveAddr;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteAddress;
    logic [DATA_W-1:0] DataIn;
    logic [NREG-1:0]   Busy;

    modport master (
        output ReqValid0, ReqAddr0, ReqData0,
        output ReqValid1, ReqAddr1, ReqData1,
        output ReadReq, Reserve, ReserveAddr,
        input  ReqReady0, ReqReady1, ReadGnt,
        input  RegWrite, WriteAddress, DataIn, Busy
    );

    modport slave (
        input  ReqValid0, ReqAddr0, ReqData0,
        input  ReqValid1, ReqAddr1, ReqData1,
        input  ReadReq, Reserve, ReserveAddr,
        output ReqReady0, ReqReady1, ReadGnt,
        output RegWrite, WriteAddress, DataIn, Busy
    );
endinterface

// File: rtl/mips_regfile_port_sched.sv
// Arbitrates the register file's single port between ALU writeback,
// load writeback and decode reads; keeps a pending-write scoreboard.
module mips_regfile_port_sched #(
    parameter int ADDR_W          = 5,
    parameter int DATA_W          = 32,
    parameter int MAX_READ_STREAK = 2
) (
    input logic                      CLK,
    input logic                      RESET_N,
    mips_regfile_port_sched_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam int SW   = $clog2(MAX_READ_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_READ_STREAK);

    logic [SW-1:0]     streak_q, streak_d;
    logic              last_q, last_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] di_q, di_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic              write_wait;
    logic              force_write;
    logic              read_gnt;
    logic              wr_gnt;
    logic              win1;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Port arbitration: reads win unless writes have waited too long.
    always_comb begin
        write_wait  = bus.ReqValid0 | bus.ReqValid1;
        force_write = write_wait & (streak_q == STREAK_MAX);
        read_gnt    = bus.ReadReq & ~force_write;
        wr_gnt      = ~read_gnt & write_wait;
        if (bus.ReqValid0 & bus.ReqValid1) begin
            win1 = ~last_q;
        end else begin
            win1 = bus.ReqValid1;
        end
        win_addr = win1 ? bus.ReqAddr1 : bus.ReqAddr0;
        win_data = win1 ? bus.ReqData1 : bus.ReqData0;
    end

    // Next state: write register, streak, round-robin and scoreboard.
    always_comb begin
        streak_d = streak_q;
        last_d   = last_q;
        rw_d     = 1'b0;
        wa_d     = wa_q;
        di_d     = di_q;
        busy_d   = busy_q;
        if (wr_gnt) begin
            streak_d         = '0;
            last_d           = win1;
            rw_d             = |win_addr;
            wa_d             = win_addr;
            di_d             = win_data;
            busy_d[win_addr] = 1'b0;
        end else if (!write_wait) begin
            streak_d = '0;
        end else if (read_gnt) begin
            streak_d = streak_q + SW'(1);
        end
        // A reservation in the same cycle names a newer producer.
        if (bus.Reserve && (|bus.ReserveAddr)) begin
            busy_d[bus.ReserveAddr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            streak_q <= '0;
            last_q   <= 1'b1;
            rw_q     <= 1'b0;
            wa_q     <= '0;
            di_q     <= '0;
            busy_q   <= '0;
        end else begin
            streak_q <= streak_d;
            last_q   <= last_d;
            rw_q     <= rw_d;
            wa_q     <= wa_d;
            di_q     <= di_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.ReqReady0    = wr_gnt & ~win1;
    assign bus.ReqReady1    = wr_gnt & win1;
    assign bus.ReadGnt      = read_gnt;
    assign bus.RegWrite     = rw_q;
    assign bus.WriteAddress = wa_q;
    assign bus.DataIn       = di_q;
    assign bus.Busy         = busy_q;
endmodule

// File: doc/mips_regfile_port_sched.md
# mips_regfile_port_sched

Scheduler for the single shared port of the MIPS register file. Two writeback requesters compete for the one write port: req0 is ALU writeback and req1 is load writeback. A decode-stage read request also competes, because the register file only updates its read outputs in cycles where RegWrite is low. The block arbitrates between all three, drives the register file's RegWrite/WriteAddress/DataIn from registers, and keeps a per-register pending-write scoreboard for hazard detection.

## Interface
Parameters:
- ADDR_W, 5, register address width (32 registers).
- DATA_W, 32, register data width.
- MAX_READ_STREAK, 2, maximum number of consecutive read grants while a write is waiting (must be ≥1).

Ports:
- CLK  in  1  system clock; rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ReqValid0 / ReqValid1  in  1  requester has a write pending.
- ReqAddr0 / ReqAddr1  in  ADDR_W  destination register.
- ReqData0 / ReqData1  in  DATA_W  write data.
- ReqReady0 / ReqReady1  out  1  write accepted this cycle (combinational).
- ReadReq  in  1  decode needs a register-file read cycle.
- ReadGnt  out  1  read cycle granted (combinational); RegWrite is low on the following edge.
- Reserve  in  1  decode marks a destination as pending.
- ReserveAddr  in  ADDR_W  register to reserve.
- RegWrite  out  1  registered write enable to the register file.
- WriteAddress  out  ADDR_W  registered write address.
- DataIn  out  DATA_W  registered write data.
- Busy  out  2^ADDR_W  scoreboard; bit i high means register i has an outstanding write.

## Operation
Handshake:
- A write transfers in a cycle where ReqValidN & ReqReadyN.
- Once ReqValidN is raised, the requester holds it, with ReqAddrN/ReqDataN stable, until the transfer.
- At most one of ReqReady0, ReqReady1 and ReadGnt is high in any cycle.

Arbitration (combinational, from inputs and registered state):
- write_wait = ReqValid0 | ReqValid1.
- force_write = write_wait & (streak == MAX_READ_STREAK).
- ReadGnt = ReadReq & ~force_write.
- When ~ReadGnt and write_wait: grant one write requester.
  - If only one is valid, it wins.
  - If both are valid, round-robin: the requester not granted last wins.
  - last_grant updates to the winner on each transfer.
  - last_grant resets to 1, so req0 wins the first tie.

Read streak counter (0..MAX_READ_STREAK):
- Increments on an edge with ReadGnt & write_wait.
- Clears to 0 on any write transfer, or on an edge where write_wait is low.
- Otherwise holds.

Write output register:
- On a transfer, the next edge loads WriteAddress/DataIn from the winner.
- RegWrite = 1 on that edge, unless the address is 0; writes to $0 are accepted and discarded with RegWrite = 0.
- On edges without a transfer: RegWrite = 0; WriteAddress/DataIn hold their previous values.

Scoreboard:
- On an edge with Reserve and ReserveAddr ≠ 0, Busy[ReserveAddr] sets.
- On an edge with a write transfer to address a, Busy[a] clears.
- Reserve and transfer on the same register in the same edge: set wins, because a newer producer exists.
- Busy[0] is constant 0.
- Busy is not checked against writes; a write to a non-busy register is legal.

## Timing
- Reset (asynchronous, while RESET_N is low): RegWrite = 0, WriteAddress = 0, DataIn = 0, Busy = 0, streak = 0, last_grant = 1. ReqReady0/1 and ReadGnt follow their combinational equations.
- Reset asserted mid-operation: all state clears immediately. A handshake in progress does not complete, and the requester must re-present it.
- Write latency: transfer in cycle T gives RegWrite high in cycle T+1. Busy clears in T+1.
- Read grant in cycle T gives RegWrite = 0 in cycle T+1, so the register file updates its read outputs that edge.
- Throughput: one write per cycle when ReadReq is low.
- Worst-case write wait while ReadReq stays high: MAX_READ_STREAK cycles.
- No combinational path from ReadReq or Reserve to RegWrite/WriteAddress/DataIn/Busy.

## Test plan
- Reset: hold RESET_N low with random inputs → RegWrite = 0, Busy = 0, WriteAddress = 0. Release, then ReqValid0 with addr 5, data 0xDEADBEEF → ReqReady0 = 1; next cycle RegWrite = 1, WriteAddress = 5, DataIn = 0xDEADBEEF.
- Round-robin: both requesters valid for 4 cycles (addr 1/2, new data each transfer) → grants in order 0,1,0,1; writes to 1,2,1,2 on consecutive cycles.
- Read starvation: ReadReq held high, ReqValid1 with addr 7, MAX_READ_STREAK = 2 → ReadGnt = 1,1,0; ReqReady1 high in cycle 3; RegWrite high in cycle 4; then ReadGnt resumes.
- Register $0: ReqValid0 with addr 0, data 0x1234 → ReqReady0 = 1; next cycle RegWrite = 0; Busy[0] stays 0.
- Scoreboard collision: Reserve with addr 9 → Busy[9] = 1. Write transfer to 9 together with Reserve addr 9 → Busy[9] stays 1. A later transfer to 9 alone → Busy[9] = 0.
- Mid-operation reset: pulse RESET_N low with Busy = 0x0000_0280 and streak = 1 → Busy = 0 and streak = 0 asynchronously; first post-reset tie grants req0.
